fetch_stage: RTL and testbench

- IF stage plus IF/ID pipeline register of the P7 pipelined MIPS microsystem.
- Owns the PC register and selects next PC from: reset, exception vector, EPC (eret), decode-stage redirect (mux_pc_sel/npc), or PC+4.
- Drives instruction memory address; latches instruction, PC and fetch-exception info into D for the decode control unit and comparator.

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage and IF/ID pipeline register with PC selection
//
// Optional feature macro: FETCH_PERF_CNT_EN (adds fetch_cnt and flush_cnt outputs).
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous active-high reset
//   stall        in   1   hold PC and IF/ID
//   mux_pc_sel   in   1   1 = next PC is npc, 0 = PC+4
//   npc          in  32   decode-computed branch/jump target
//   branch_d     in   1   instruction in D is a branch/jump (next fetch is a delay slot)
//   exc_req      in   1   exception/interrupt taken this cycle
//   eret_req     in   1   eret committing this cycle
//   epc          in  32   CP0 EPC value
//   imem_rdata   in  32   combinational instruction memory read data
//   imem_addr    out 32   instruction memory address (= pc_f)
//   pc_f         out 32   current fetch PC
//   instr_d      out 32   instruction in D
//   pc_d         out 32   PC of instruction in D
//   pc8_d        out 32   pc_d + 8 link value
//   exc_valid_d  out  1   D carries a fetch exception
//   exc_code_d   out  5   ExcCode for D (4 = AdEL)
//   bd_d         out  1   D is in a branch delay slot
//   fetch_cnt    out 32   (FETCH_PERF_CNT_EN) IF/ID capture count, wrapping
//   flush_cnt    out 16   (FETCH_PERF_CNT_EN) flush count, saturating
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter int unsigned IM_WORDS   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        mux_pc_sel,
  input  logic [31:0] npc,
  input  logic        branch_d,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        exc_valid_d,
  output logic [4:0]  exc_code_d,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [15:0] flush_cnt,
`endif
  output logic        bd_d
);

  // Upper bound computed in 33 bits so a range ending at 2^32 cannot wrap.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  logic        flush;
  logic        fetch_fault;
  logic [31:0] pc_next;

  assign flush       = exc_req | eret_req;
  assign fetch_fault = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || ({1'b0, pc_f} >= IM_END);

  // Redirects from CP0 override stall; a decode redirect under stall is
  // dropped because decode holds and re-presents it next cycle.
  always_comb begin
    pc_next = pc_f + 32'd4;
    if (exc_req)
      pc_next = EXC_VECTOR;
    else if (eret_req)
      pc_next = epc;
    else if (stall)
      pc_next = pc_f;
    else if (mux_pc_sel)
      pc_next = npc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc_f <= RESET_PC;
    else
      pc_f <= pc_next;
  end

  // On flush the bubble takes the PC now being fetched, so an exception
  // raised against the bubble still records a meaningful EPC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d     <= '0;
      pc_d        <= RESET_PC;
      exc_valid_d <= 1'b0;
      exc_code_d  <= '0;
      bd_d        <= 1'b0;
    end else if (flush) begin
      instr_d     <= '0;
      pc_d        <= pc_next;
      exc_valid_d <= 1'b0;
      exc_code_d  <= '0;
      bd_d        <= 1'b0;
    end else if (!stall) begin
      instr_d     <= fetch_fault ? 32'd0 : imem_rdata;
      pc_d        <= pc_f;
      exc_valid_d <= fetch_fault;
      exc_code_d  <= fetch_fault ? EXC_ADEL : 5'd0;
      bd_d        <= branch_d;
    end
  end

  assign imem_addr = pc_f;
  assign pc8_d     = pc_d + 32'd8;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!flush && !stall)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (flush && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with directed and random stimulus
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        mux_pc_sel;
  logic [31:0] npc;
  logic        branch_d;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        exc_valid_d;
  logic [4:0]  exc_code_d;
  logic        bd_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .mux_pc_sel  (mux_pc_sel),
    .npc         (npc),
    .branch_d    (branch_d),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .imem_rdata  (imem_rdata),
    .imem_addr   (imem_addr),
    .pc_f        (pc_f),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc8_d       (pc8_d),
    .exc_valid_d (exc_valid_d),
    .exc_code_d  (exc_code_d),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt),
`endif
    .bd_d        (bd_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small instruction memory image; index by word address bits [7:2].
  logic [31:0] mem [64];
  assign imem_rdata = mem[imem_addr[7:2]];

  int checks = 0;
  int errors = 0;

  // Reference state: what each architectural output should hold.
  logic [31:0] m_pc, m_instr, m_pcd;
  logic        m_exc, m_bd;
  logic [4:0]  m_code;
  longint      m_fetch, m_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h3000; m_instr = 0; m_pcd = 32'h3000;
    m_exc = 0; m_code = 0; m_bd = 0;
    m_fetch = 0; m_flush = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc_f"}, pc_f, m_pc);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".instr_d"}, instr_d, m_instr);
    chk({tag, ".pc_d"}, pc_d, m_pcd);
    chk({tag, ".pc8_d"}, pc8_d, m_pcd + 32'd8);
    chk({tag, ".exc_valid_d"}, {31'd0, exc_valid_d}, {31'd0, m_exc});
    chk({tag, ".exc_code_d"}, {27'd0, exc_code_d}, {27'd0, m_code});
    chk({tag, ".bd_d"}, {31'd0, bd_d}, {31'd0, m_bd});
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".fetch_cnt"}, fetch_cnt, m_fetch[31:0]);
    chk({tag, ".flush_cnt"}, {16'd0, flush_cnt}, (m_flush > 65535) ? 32'hFFFF : m_flush[31:0]);
`endif
  endtask

  // Advance one clock: compute the expected post-edge state from the
  // currently driven inputs, let the edge happen, compare at the falling edge.
  task automatic step(input string tag);
    logic        bad;
    logic [31:0] word;
    logic [31:0] target;
    bad  = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc >= 32'h3000 + 32'd4 * 32'd4096);
    word = mem[m_pc[7:2]];
    if (exc_req || eret_req) begin
      target  = exc_req ? 32'h4180 : epc;
      m_pc    = target;
      m_pcd   = target;
      m_instr = 0; m_exc = 0; m_code = 0; m_bd = 0;
      m_flush++;
    end else if (!stall) begin
      m_pcd   = m_pc;
      m_instr = bad ? 32'd0 : word;
      m_exc   = bad;
      m_code  = bad ? 5'd4 : 5'd0;
      m_bd    = branch_d;
      m_pc    = mux_pc_sel ? npc : m_pc + 32'd4;
      m_fetch++;
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    stall = 0; mux_pc_sel = 0; npc = 0; branch_d = 0;
    exc_req = 0; eret_req = 0; epc = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h012A_5020;

    idle_inputs();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    // Free run: instr_d lags pc_f by one cycle.
    step("run1");
    chk("run1.instr_word0", instr_d, 32'h2008_0001);
    step("run2");
    chk("run2.pc_f", pc_f, 32'h3008);

    // Decode redirect with the instruction at 0x3008 marked as delay slot.
    mux_pc_sel = 1; npc = 32'h3040; branch_d = 1;
    step("redir");
    chk("redir.pc_f_const", pc_f, 32'h3040);
    chk("redir.instr_const", instr_d, 32'h012A_5020);
    chk("redir.bd_const", {31'd0, bd_d}, 32'd1);

    // Stall with a pending redirect: everything holds.
    stall = 1; mux_pc_sel = 1; npc = 32'h3100; branch_d = 0;
    step("stall1");
    step("stall2");
    chk("stall2.pc_f_const", pc_f, 32'h3040);
    stall = 0; mux_pc_sel = 0;
    step("resume");
    chk("resume.pc_f_const", pc_f, 32'h3044);

    // Misaligned fetch raises AdEL in D.
    mux_pc_sel = 1; npc = 32'h3042;
    step("mis_redir");
    mux_pc_sel = 0;
    step("mis_fetch");
    chk("mis.exc_code_const", {27'd0, exc_code_d}, 32'd4);
    chk("mis.pc_d_const", pc_d, 32'h3042);

    // Below the legal range.
    mux_pc_sel = 1; npc = 32'h0000_1000;
    step("oor_redir");
    mux_pc_sel = 0;
    step("oor_fetch");
    chk("oor.exc_valid_const", {31'd0, exc_valid_d}, 32'd1);

    // exc_req beats eret_req and stall.
    exc_req = 1; eret_req = 1; stall = 1; epc = 32'h3010; branch_d = 1;
    step("exc_all");
    chk("exc_all.pc_f_const", pc_f, 32'h4180);
    chk("exc_all.pc_d_const", pc_d, 32'h4180);
    exc_req = 0; stall = 0; branch_d = 0;
    step("eret");
    chk("eret.pc_f_const", pc_f, 32'h3010);
    eret_req = 0;

    // Run to 0x3020 then reset asynchronously between edges.
    for (int i = 0; i < 4; i++) step("to3020");
    chk("pre_reset.pc_f_const", pc_f, 32'h3020);
    #1 reset = 1'b1;
    model_reset();
    #1 check_all("async_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step("post_reset");
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt_five", fetch_cnt, 32'd5);
`endif

    // Random phase.
    for (int n = 0; n < 400; n++) begin
      int r;
      idle_inputs();
      stall      = ($urandom_range(0, 4) == 0);
      mux_pc_sel = ($urandom_range(0, 3) == 0);
      branch_d   = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r == 0)
        npc = 32'h3000 + ($urandom_range(0, 255) << 2) + $urandom_range(1, 3);
      else if (r == 1)
        npc = $urandom;
      else
        npc = 32'h3000 + ($urandom_range(0, 63) << 2);
      exc_req  = ($urandom_range(0, 19) == 0);
      eret_req = ($urandom_range(0, 14) == 0);
      epc      = 32'h3000 + ($urandom_range(0, 63) << 2);
      if ($urandom_range(0, 9) == 0) epc = epc + 32'd2;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
